// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI4-Stream definitions for the stream library.
//   axis_parameters_t        - sideband width record carried by every AXIS stage
//   AXIS_PARAMETERS_DEFAULT  - default widths (4-byte data, 4-bit id/dest, 2-bit user)
//   AXIS_FIFO_DEPTH_DEFAULT  - default number of beats buffered by axis_fifo
//   tdata_width/tkeep_width/beat_width - derived bus widths for a parameter record
//   axis_beat_t              - one packed beat at the default widths
package axis_pkg;

  typedef struct packed {
    int unsigned TDATA_BYTES;
    int unsigned TID_WIDTH;
    int unsigned TDEST_WIDTH;
    int unsigned TUSER_WIDTH;
  } axis_parameters_t;

  localparam axis_parameters_t AXIS_PARAMETERS_DEFAULT = '{
    TDATA_BYTES: 4,
    TID_WIDTH:   4,
    TDEST_WIDTH: 4,
    TUSER_WIDTH: 2
  };

  localparam int AXIS_FIFO_DEPTH_DEFAULT = 16;

  function automatic int tdata_width(input axis_parameters_t p);
    return 8 * int'(p.TDATA_BYTES);
  endfunction

  function automatic int tkeep_width(input axis_parameters_t p);
    return int'(p.TDATA_BYTES);
  endfunction

  // Total bits of {tdata, tkeep, tlast, tid, tdest, tuser}
  function automatic int beat_width(input axis_parameters_t p);
    return tdata_width(p) + tkeep_width(p) + 1 + int'(p.TID_WIDTH) +
           int'(p.TDEST_WIDTH) + int'(p.TUSER_WIDTH);
  endfunction

  typedef struct packed {
    logic [tdata_width(AXIS_PARAMETERS_DEFAULT)-1:0]  tdata;
    logic [tkeep_width(AXIS_PARAMETERS_DEFAULT)-1:0]  tkeep;
    logic                                             tlast;
    logic [AXIS_PARAMETERS_DEFAULT.TID_WIDTH-1:0]     tid;
    logic [AXIS_PARAMETERS_DEFAULT.TDEST_WIDTH-1:0]   tdest;
    logic [AXIS_PARAMETERS_DEFAULT.TUSER_WIDTH-1:0]   tuser;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_if.sv
// axis_fifo_if: one AXI4-Stream link.
//   tvalid/tready handshake, tdata/tkeep/tlast/tid/tdest/tuser payload.
//   master modport drives the payload and tvalid, slave modport drives tready.
interface axis_fifo_if
  import axis_pkg::*;
#(
  parameter axis_parameters_t P = AXIS_PARAMETERS_DEFAULT
) ();

  logic                        tvalid;
  logic                        tready;
  logic [tdata_width(P)-1:0]   tdata;
  logic [tkeep_width(P)-1:0]   tkeep;
  logic                        tlast;
  logic [P.TID_WIDTH-1:0]      tid;
  logic [P.TDEST_WIDTH-1:0]    tdest;
  logic [P.TUSER_WIDTH-1:0]    tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: simple dual-port register array.
//   clk_i      - write clock
//   wr_en_i    - write strobe, wr_addr_i/wr_data_i written on the rising edge
//   rd_addr_i  - read address, rd_data_o follows it combinationally
module axis_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: synchronous first-word-fall-through AXI4-Stream FIFO.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   s_axis     - input stream (slave side), tready = not full
//   m_axis     - output stream (master side), payload from a holding register
//   occupancy  - beats currently stored, 0..DEPTH
// Optional build macro AXIS_FIFO_PACKET_MODE_EN: m_axis_tvalid is held off until
// a complete packet (tlast beat) is stored, or the FIFO is full so packets longer
// than DEPTH cut through instead of deadlocking.
module axis_fifo
  import axis_pkg::*;
#(
  parameter axis_parameters_t AXIS_PARAMS = AXIS_PARAMETERS_DEFAULT,
  parameter int               DEPTH       = AXIS_FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_fifo_if.slave             s_axis,
  axis_fifo_if.master            m_axis,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int BW = beat_width(AXIS_PARAMS);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = OW'(1);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] out_q, out_d;
  logic [BW-1:0] in_beat, rd_beat;
  logic          accept, pop;

  assign in_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast,
                    s_axis.tid, s_axis.tdest, s_axis.tuser};

  // ready_q is the registered not-full flag; masking with rst keeps tready low
  // throughout a multi-cycle reset without a path from m_axis.tready.
  assign s_axis.tready = ready_q && !rst;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign pop           = valid_q && m_axis.tready;

  assign m_axis.tvalid = valid_q;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = out_q;
  assign occupancy = occ_q;

  axis_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_beat),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (rd_beat)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (accept && !pop)      occ_d = occ_q + OCC_ONE;
    else if (!accept && pop) occ_d = occ_q - OCC_ONE;
  end

  // Next head beat. When the slot being written this cycle becomes the head
  // (FIFO otherwise empty) the beat is taken straight from the input, since
  // the array only holds it after the edge. An empty FIFO keeps the last beat.
  always_comb begin
    out_d = out_q;
    if (occ_d != '0) begin
      out_d = (accept && (wr_ptr_q == rd_ptr_d)) ? in_beat : rd_beat;
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [AW:0] pkt_q, pkt_d;
  logic        acc_last, pop_last;

  assign acc_last = accept && s_axis.tlast;
  assign pop_last = pop && m_axis.tlast;

  always_comb begin
    pkt_d = pkt_q;
    if (acc_last && !pop_last)      pkt_d = pkt_q + OCC_ONE;
    else if (!acc_last && pop_last) pkt_d = pkt_q - OCC_ONE;
    valid_d = (pkt_d != '0) || (occ_d == FULL_CNT);
    ready_d = (occ_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_q <= '0;
    else     pkt_q <= pkt_d;
  end
`else
  always_comb begin
    valid_d = (occ_d != '0);
    ready_d = (occ_d != FULL_CNT);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: scoreboard bench for axis_fifo (DEPTH=16, default widths).
// Directed sequences push expected beats on acceptance; a monitor pops and
// compares on every output handshake and tracks occupancy as accepted-popped.
module tb_axis_fifo;
  import axis_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] occupancy;

  int checks   = 0;
  int failures = 0;

  axis_beat_t exp_q[$];
  int         model_occ = 0;
  bit         seen_rst  = 1'b0;
  bit         rand_done = 1'b0;

  axis_fifo_if s_if ();
  axis_fifo_if m_if ();

  axis_fifo #(
    .AXIS_PARAMS (AXIS_PARAMETERS_DEFAULT),
    .DEPTH       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at time %0t", name, $time);
  endfunction

  function automatic axis_beat_t mk_beat(int unsigned v, bit last);
    axis_beat_t b;
    b.tdata = v;
    b.tkeep = 4'hF;
    b.tlast = last;
    b.tid   = 4'(v);
    b.tdest = 4'(v + 3);
    b.tuser = 2'(v);
    return b;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  // with tvalid still high so the caller can chain beats back-to-back.
  task automatic send_beat(input axis_beat_t b);
    bit done = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.tdata;
    s_if.tkeep  = b.tkeep;
    s_if.tlast  = b.tlast;
    s_if.tid    = b.tid;
    s_if.tdest  = b.tdest;
    s_if.tuser  = b.tuser;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (s_if.tready) begin
        exp_q.push_back(b);
        done = 1'b1;
      end
    end
    if (!done) fail_timeout("send_beat");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_if.tvalid) done = 1'b1;
    end
    if (!done) fail_timeout("drain");
  endtask

  // Monitor: occupancy model and output scoreboard
  always @(negedge clk) begin
    axis_beat_t got;
    axis_beat_t exp;
    if (rst) begin
      seen_rst  = 1'b1;
      model_occ = 0;
      exp_q.delete();
    end else if (seen_rst) begin
      check("occupancy", 64'(occupancy), 64'(model_occ));
      if (s_if.tvalid && s_if.tready) model_occ++;
      if (m_if.tvalid && m_if.tready) begin
        got.tdata = m_if.tdata;
        got.tkeep = m_if.tkeep;
        got.tlast = m_if.tlast;
        got.tid   = m_if.tid;
        got.tdest = m_if.tdest;
        got.tuser = m_if.tuser;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: got %0h with empty scoreboard", got);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 64'(got), 64'(exp));
        end
        model_occ--;
      end
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= 5'd16)
    else begin
      failures++;
      $display("FAIL occ_bound: got %0d limit 16", occupancy);
    end

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (m_if.tvalid && !m_if.tready) |=>
      (m_if.tvalid && $stable(m_if.tdata) && $stable(m_if.tlast) &&
       $stable(m_if.tid) && $stable(m_if.tkeep)))
    else begin
      failures++;
      $display("FAIL axis_hold: tvalid=%0d tdata=%0h", m_if.tvalid, m_if.tdata);
    end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_beat_t b;
    rst = 1'b1;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_tready", 64'(s_if.tready), 64'(0));
    check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_tdata", 64'(m_if.tdata), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_tready", 64'(s_if.tready), 64'(1));
    check("idle_tvalid", 64'(m_if.tvalid), 64'(0));

    // Fill to DEPTH with the consumer stalled
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send_beat(mk_beat(i, (i % 4) == 3));
    b = mk_beat(16, 1'b0);
    s_if.tdata = b.tdata;
    s_if.tkeep = b.tkeep;
    s_if.tlast = b.tlast;
    s_if.tid   = b.tid;
    s_if.tdest = b.tdest;
    s_if.tuser = b.tuser;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_tready", 64'(s_if.tready), 64'(0));
      check("full_occ", 64'(occupancy), 64'(16));
      check("full_tvalid", 64'(m_if.tvalid), 64'(1));
      check("full_head", 64'(m_if.tdata), 64'(0));
    end

    // Pop from full: no accept in the popping cycle, then stream through wrap
    @(posedge clk);
    #1 m_if.tready = 1'b1;
    @(negedge clk);
    check("full_pop_no_accept", 64'(s_if.tready), 64'(0));
    for (int i = 16; i < 36; i++) send_beat(mk_beat(i, (i % 4) == 3));
    s_if.tvalid = 1'b0;
    wait_drain();
    check("empty_tvalid", 64'(m_if.tvalid), 64'(0));
    check("empty_hold_tdata", 64'(m_if.tdata), 64'(35));
    check("empty_occ", 64'(occupancy), 64'(0));

    // Accept+pop at occupancy 1 keeps tvalid high
    @(posedge clk);
    #1;
    send_beat(mk_beat(100, 1'b1));
    send_beat(mk_beat(101, 1'b1));
    send_beat(mk_beat(102, 1'b1));
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("nobubble_tvalid", 64'(m_if.tvalid), 64'(1));
    check("nobubble_occ", 64'(occupancy), 64'(1));
    check("nobubble_tdata", 64'(m_if.tdata), 64'(102));
    wait_drain();

    // Random handshakes with random sideband
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          while ($urandom_range(1, 0) == 0) begin
            @(posedge clk);
            #1;
          end
          b.tdata = $urandom();
          b.tkeep = 4'($urandom_range(15, 0));
          b.tlast = (i == 1499) ? 1'b1 : 1'($urandom_range(1, 0));
          b.tid   = 4'($urandom_range(15, 0));
          b.tdest = 4'($urandom_range(15, 0));
          b.tuser = 2'($urandom_range(3, 0));
          send_beat(b);
          s_if.tvalid = 1'b0;
        end
        rand_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!(rand_done && exp_q.size() == 0) && cyc < 40000) begin
          m_if.tready = ($urandom_range(9, 0) < 3);
          @(posedge clk);
          #1;
          cyc++;
        end
        if (cyc >= 40000) fail_timeout("random_phase");
        m_if.tready = 1'b1;
      end
    join
    wait_drain();

    // Reset with 7 beats stored discards them
    @(posedge clk);
    #1 m_if.tready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(mk_beat(50 + i, 1'b0));
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_occ", 64'(occupancy), 64'(7));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_occ", 64'(occupancy), 64'(0));
    check("post_rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("post_rst_tready", 64'(s_if.tready), 64'(1));
    @(posedge clk);
    #1;
    send_beat(mk_beat(200, 1'b1));
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("post_rst_first_tvalid", 64'(m_if.tvalid), 64'(1));
    check("post_rst_first_tdata", 64'(m_if.tdata), 64'(200));
    @(posedge clk);
    #1 m_if.tready = 1'b1;
    wait_drain();

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // tvalid waits for the tlast beat
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      send_beat(mk_beat(400 + k, k == 2));
      s_if.tvalid = 1'b0;
      @(negedge clk);
      check("pkt_tvalid", 64'(m_if.tvalid), (k == 2) ? 64'(1) : 64'(0));
    end
    wait_drain();

    // 20-beat packet into 16 entries cuts through once full
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send_beat(mk_beat(500 + i, 1'b0));
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("long_pkt_occ", 64'(occupancy), 64'(16));
    check("long_pkt_tvalid", 64'(m_if.tvalid), 64'(1));
    check("long_pkt_tready", 64'(s_if.tready), 64'(0));
    @(posedge clk);
    #1;
    for (int i = 16; i < 20; i++) send_beat(mk_beat(500 + i, i == 19));
    s_if.tvalid = 1'b0;
    wait_drain();
`endif

    check("final_occ", 64'(occupancy), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
